line_buffer_ctrl: RTL

//  Scheduler for the ping-pong scanline buffer between the PPU pixel stream and the VGA timing generator.
//  - PPU side: decimates each 1600-clock PPU line to 800 writes into the bank not being read.
//  - End of each PPU line: swaps banks; VGA side reads the completed bank by h_cnt.
//  - Gates VGA timing start until the first line is buffered; flags overrun/underrun.

---
 rtl/line_buffer_ctrl_pkg.sv | 17 +
 rtl/line_buffer_ctrl_phase_cnt.sv | 44 ++++
 rtl/line_buffer_ctrl.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/line_buffer_ctrl_pkg.sv
// Shared definitions for the ping-pong scanline buffer controller.
package line_buffer_ctrl_pkg;

    // Controller states (2-bit encodings kept stable for existing tooling)
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FILL = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    // Bank encoding
    localparam logic BANK_A = 1'b0;
    localparam logic BANK_B = 1'b1;

    // Default line geometry
    localparam int LINE_PIXELS_DEF = 800;
    localparam int DECIM_DEF       = 2;

endpackage

// File: rtl/line_buffer_ctrl_phase_cnt.sv
// PPU line phase counter: tracks the pixel index within a PPU line and
// flags the last pixel and the decimated write phase.
module line_phase_cnt #(
    parameter int LINE_CLKS = 1600,
    parameter int DECIM     = 2,
    parameter int P_W       = $clog2(LINE_CLKS)
) (
    input  logic           pclk,
    input  logic           rst_n,
    input  logic           load,
    output logic [P_W-1:0] p,
    output logic           active,
    output logic           last,
    output logic           wr_phase,
    output logic           restart
);

    logic [P_W-1:0] p_reg;
    logic           act_reg;

    // p_reg/act_reg describe the current cycle unless a line start overrides them
    assign active   = load | act_reg;
    assign p        = load ? '0 : p_reg;
    assign last     = active && (p == P_W'(LINE_CLKS - 1));
    assign wr_phase = active && ((p & P_W'(DECIM - 1)) == '0);
    assign restart  = load && act_reg && (p_reg != '0);

    // Advance the pixel index; the line goes inactive after its last pixel
    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            p_reg   <= '0;
            act_reg <= 1'b0;
        end else if (active) begin
            if (last) begin
                p_reg   <= '0;
                act_reg <= 1'b0;
            end else begin
                p_reg   <= p + P_W'(1);
                act_reg <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/line_buffer_ctrl.sv
// Ping-pong scanline buffer scheduler between the PPU pixel stream and
// the VGA timing generator: decimated writes into the idle bank, bank swap
// at end of line, VGA start gating and overrun/underrun flags.
module line_buffer_ctrl
    import line_buffer_ctrl_pkg::*;
#(
    parameter int LINE_PIXELS = LINE_PIXELS_DEF,
    parameter int DECIM       = DECIM_DEF,
    parameter int ADDR_W      = 10,
    parameter int START_DELAY = 3203
) (
    input  logic              pclk,
    input  logic              rst_n,
    input  logic              ppu_line_start,
    input  logic [ADDR_W-1:0] vga_h_cnt,
    input  logic              vga_blank,
    output logic              wr_en_a,
    output logic              wr_en_b,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_bank,
    output logic              rd_bank_q,
    output logic              vga_en,
    output logic              line_swap,
    output logic              overrun,
    output logic              underrun
);

    localparam int PPU_LINE_CLKS = LINE_PIXELS * DECIM;
    localparam int P_W           = $clog2(PPU_LINE_CLKS);
    localparam int DSH           = $clog2(DECIM);
    localparam int SC_W          = $clog2(START_DELAY + 1);
    localparam int GAP_LIMIT     = 2 * PPU_LINE_CLKS;
    localparam int G_W           = $clog2(GAP_LIMIT + 1);

    logic [P_W-1:0]  p;
    logic            active;
    logic            last;
    logic            wr_phase;
    logic            restart;
    logic [1:0]      state;
    logic [SC_W-1:0] start_cnt;
    logic [G_W-1:0]  gap;
    logic [G_W-1:0]  gap_nxt;
    logic [1:0]      swap_pipe;

    line_phase_cnt #(
        .LINE_CLKS (PPU_LINE_CLKS),
        .DECIM     (DECIM),
        .P_W       (P_W)
    ) u_phase (
        .pclk     (pclk),
        .rst_n    (rst_n),
        .load     (ppu_line_start),
        .p        (p),
        .active   (active),
        .last     (last),
        .wr_phase (wr_phase),
        .restart  (restart)
    );

    // Blanking parks the read address at 0
    assign rd_addr   = vga_blank ? '0 : vga_h_cnt;
    assign line_swap = swap_pipe[1];

    // Registered write strobe into the bank not being read
    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            wr_en_a <= 1'b0;
            wr_en_b <= 1'b0;
            wr_addr <= '0;
        end else begin
            wr_en_a <= wr_phase && (rd_bank == BANK_B);
            wr_en_b <= wr_phase && (rd_bank == BANK_A);
            if (wr_phase)
                wr_addr <= ADDR_W'(p >> DSH);
        end
    end

    // Bank toggle after the last pixel; swap pulse trails by one cycle
    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            rd_bank   <= BANK_A;
            rd_bank_q <= BANK_A;
            swap_pipe <= '0;
        end else begin
            if (last)
                rd_bank <= ~rd_bank;
            rd_bank_q <= rd_bank;
            swap_pipe <= {swap_pipe[0], last};
        end
    end

    // Startup FSM: counter counts from the first line start so vga_en
    // rises exactly START_DELAY cycles later
    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            start_cnt <= '0;
            vga_en    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ppu_line_start) begin
                        state     <= ST_FILL;
                        start_cnt <= SC_W'(1);
                    end
                end
                ST_FILL: begin
                    if (start_cnt == SC_W'(START_DELAY - 1)) begin
                        state  <= ST_RUN;
                        vga_en <= 1'b1;
                    end
                    if (start_cnt != SC_W'(START_DELAY))
                        start_cnt <= start_cnt + SC_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Cycles since the last swap, saturating at the underrun limit
    always_comb begin
        gap_nxt = gap;
        if (state == ST_IDLE || last)
            gap_nxt = '0;
        else if (gap != G_W'(GAP_LIMIT))
            gap_nxt = gap + G_W'(1);
    end

    // Gap counter and sticky error flags
    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            gap      <= '0;
            overrun  <= 1'b0;
            underrun <= 1'b0;
        end else begin
            gap <= gap_nxt;
            if (restart)
                overrun <= 1'b1;
            if (state == ST_RUN && gap_nxt == G_W'(GAP_LIMIT))
                underrun <= 1'b1;
        end
    end

endmodule
